// File: rtl/soc_pkg.sv
// Shared SoC definitions for the factorial accelerator: register offsets,
// FSM state encoding and the default operand limit.
package soc_pkg;

   localparam logic [1:0] FACT_REG_N   = 2'b00;
   localparam logic [1:0] FACT_REG_GO  = 2'b01;
   localparam logic [1:0] FACT_REG_ST  = 2'b10;
   localparam logic [1:0] FACT_REG_RES = 2'b11;

   localparam int unsigned FACT_MAX_N = 12;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fact_state_t;

endpackage

// File: rtl/soc_fact_unit_dp.sv
// Factorial datapath: down-counter over the latched operand and a running
// product register, multiplied one operand step per cycle.
module fact_dp #(
   parameter int unsigned N_W    = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [N_W-1:0]    n_i,
   output logic              cnt_le1_o,
   output logic [DATA_W-1:0] product_o
);

   logic [N_W-1:0]    cnt_q,     cnt_d;
   logic [DATA_W-1:0] product_q, product_d;

   // Load restarts the product at 1; step folds in the current count and decrements
   always_comb begin
      cnt_d     = cnt_q;
      product_d = product_q;
      if (load_i) begin
         cnt_d     = n_i;
         product_d = DATA_W'(1);
      end else if (step_i) begin
         cnt_d     = cnt_q - N_W'(1);
         product_d = product_q * DATA_W'(cnt_q);
      end
   end

   // Datapath state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         product_q <= DATA_W'(1);
      end else begin
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign cnt_le1_o = (cnt_q <= N_W'(1));
   assign product_o = product_q;

endmodule

// File: rtl/soc_fact_unit.sv
// Memory-mapped iterative factorial accelerator: register file, start decode,
// IDLE/BUSY control FSM and combinational read mux.
// Optional feature macro FACT_IRQ_EN adds a sticky completion interrupt (irq).
module soc_fact_unit
   import soc_pkg::*;
#(
   parameter int unsigned N_W    = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MAX_N  = FACT_MAX_N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WE,
   input  logic [1:0]        A,
   input  logic [DATA_W-1:0] WD,
`ifdef FACT_IRQ_EN
   output logic              irq,
`endif
   output logic [DATA_W-1:0] RD
);

   fact_state_t       state_q, state_d;
   logic [N_W-1:0]    n_q;
   logic              go_q;
   logic              done_q;
   logic              err_q;
   logic [DATA_W-1:0] result_q;

   logic              wr_go_c;
   logic              start_c;
   logic              over_c;
   logic              load_c;
   logic              step_c;
   logic              finish_c;
   logic              err_start_c;
   logic              cnt_le1;
   logic [DATA_W-1:0] product;
   logic              unused_wd_c;

   assign wr_go_c     = WE && (A == FACT_REG_GO);
   assign start_c     = wr_go_c && WD[0];
   assign over_c      = (n_q > N_W'(MAX_N));
   assign unused_wd_c = ^WD[DATA_W-1:N_W];

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state: accepted in-range start enters BUSY, count exhaustion leaves it
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_c && !over_c) state_d = BUSY;
         BUSY:    if (cnt_le1)            state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: datapath controls and status-update strobes
   always_comb begin
      load_c      = 1'b0;
      step_c      = 1'b0;
      finish_c    = 1'b0;
      err_start_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               if (over_c) err_start_c = 1'b1;
               else        load_c      = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_le1) finish_c = 1'b1;
            else         step_c   = 1'b1;
         end
         default: ;
      endcase
   end

   fact_dp #(
      .N_W    (N_W),
      .DATA_W (DATA_W)
   ) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load_c),
      .step_i    (step_c),
      .n_i       (n_q),
      .cnt_le1_o (cnt_le1),
      .product_o (product)
   );

   // Software-writable registers; n may change freely while BUSY
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_q  <= '0;
         go_q <= 1'b0;
      end else begin
         if (WE && (A == FACT_REG_N)) n_q  <= WD[N_W-1:0];
         if (wr_go_c)                 go_q <= WD[0];
      end
   end

   // Sticky status and result; cleared only by an accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else if (err_start_c) begin
         done_q   <= 1'b1;
         err_q    <= 1'b1;
         result_q <= '0;
      end else if (load_c) begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else if (finish_c) begin
         done_q   <= 1'b1;
         result_q <= product;
      end
   end

`ifdef FACT_IRQ_EN
   // Interrupt raised when Done is set; a Go write acknowledges it unless Done sets on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          irq <= 1'b0;
      else if (finish_c || err_start_c)  irq <= 1'b1;
      else if (wr_go_c)                  irq <= 1'b0;
   end
`endif

   // Side-effect-free read mux
   always_comb begin
      RD = '0;
      case (A)
         FACT_REG_N:   RD = DATA_W'(n_q);
         FACT_REG_GO:  RD = DATA_W'(go_q);
         FACT_REG_ST:  RD = DATA_W'({err_q, done_q});
         FACT_REG_RES: RD = result_q;
         default:      RD = '0;
      endcase
   end

endmodule

// File: tb/tb_soc_fact_unit.sv
// Directed self-checking bench for soc_fact_unit (covers FACT_IRQ_EN when defined).
module tb_soc_fact_unit;

   localparam int unsigned DATA_W = 32;
   localparam logic [1:0]  AN  = 2'b00;
   localparam logic [1:0]  AG  = 2'b01;
   localparam logic [1:0]  AS  = 2'b10;
   localparam logic [1:0]  AR  = 2'b11;

   logic              clk = 1'b0;
   logic              rst;
   logic              WE;
   logic [1:0]        A;
   logic [DATA_W-1:0] WD;
   logic [DATA_W-1:0] RD;
`ifdef FACT_IRQ_EN
   logic              irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   soc_fact_unit dut (
      .clk (clk),
      .rst (rst),
      .WE  (WE),
      .A   (A),
      .WD  (WD),
`ifdef FACT_IRQ_EN
      .irq (irq),
`endif
      .RD  (RD)
   );

   task automatic wr(input logic [1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      WE = 1'b1; A = a; WD = d;
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   task automatic chk(input logic [1:0] a, input logic [DATA_W-1:0] exp, input string tag);
      A = a;
      #1;
      n_checks++;
      assert (RD === exp) else begin
         n_fail++;
         $error("FAIL %s: RD=0x%08h expected 0x%08h", tag, RD, exp);
      end
   endtask

`ifdef FACT_IRQ_EN
   task automatic chk_irq(input logic exp, input string tag);
      n_checks++;
      assert (irq === exp) else begin
         n_fail++;
         $error("FAIL %s: irq=%b expected %b", tag, irq, exp);
      end
   endtask
`endif

   // After the start edge, poll Status every edge: 0 until edge n, then Done
   task automatic run_wait(input int edges, input logic [DATA_W-1:0] res, input string tag);
      for (int k = 1; k < edges; k++) begin
         @(posedge clk); #1;
         chk(AS, 32'd0, {tag, "_busy"});
      end
      @(posedge clk); #1;
      chk(AS, 32'd1, {tag, "_done"});
      chk(AR, res, {tag, "_res"});
   endtask

   initial begin
      rst = 1'b0; WE = 1'b0; A = AN; WD = '0;

      // Writes during reset are ignored
      repeat (2) begin
         @(negedge clk); WE = 1'b1; A = AN; WD = 32'd5;
      end
      @(negedge clk); WE = 1'b0;
      chk(AN, 32'd0, "rst_n");
      chk(AG, 32'd0, "rst_go");
      chk(AS, 32'd0, "rst_st");
      chk(AR, 32'd0, "rst_res");
      @(negedge clk); rst = 1'b1;
      #1;
      chk(AN, 32'd0, "post_rst_n");
`ifdef FACT_IRQ_EN
      chk_irq(1'b0, "rst_irq");
`endif

      // n=5 -> 120 after 5 edges
      wr(AN, 32'd5);
      chk(AN, 32'd5, "n5_rd");
      wr(AG, 32'd1);
      chk(AG, 32'd1, "go_rd");
      run_wait(5, 32'd120, "n5");

      // n=0 -> 1 after 1 edge
      wr(AN, 32'd0);
      wr(AG, 32'd1);
      run_wait(1, 32'd1, "n0");

      // n=1 -> 1 after 1 edge
      wr(AN, 32'd1);
      wr(AG, 32'd1);
      run_wait(1, 32'd1, "n1");

      // n=12 -> 479001600 after 12 edges
      wr(AN, 32'd12);
      wr(AG, 32'd1);
      run_wait(12, 32'h1C8CFC00, "n12");

      // Go=0 write: no start, result kept
      wr(AG, 32'd0);
      chk(AG, 32'd0, "go0_rd");
      @(posedge clk); #1;
      chk(AS, 32'd1, "go0_st");
      chk(AR, 32'h1C8CFC00, "go0_res");

      // n=13 -> error immediately
      wr(AN, 32'd13);
      wr(AG, 32'd1);
      chk(AS, 32'd3, "n13_st");
      chk(AR, 32'd0, "n13_res");
      @(posedge clk); #1;
      chk(AS, 32'd3, "n13_sticky");

      // n=3 after error: status cleared at start, 6 after 3 edges
      wr(AN, 32'd3);
      wr(AG, 32'd1);
      chk(AS, 32'd0, "n3_clr");
      run_wait(3, 32'd6, "n3");

      // Result register ignores writes
      wr(AR, 32'hDEADBEEF);
      wr(AS, 32'hFFFFFFFF);
      chk(AR, 32'd6, "ro_res");
      chk(AS, 32'd1, "ro_st");

      // n=6 started; n and Go rewritten while BUSY
      wr(AN, 32'd6);
      wr(AG, 32'd1);           // start edge
      wr(AN, 32'd2);           // edge 1
      wr(AG, 32'd1);           // edge 2
      chk(AN, 32'd2, "busy_n");
      chk(AS, 32'd0, "busy_st");
      run_wait(4, 32'd720, "n6");
      chk(AN, 32'd2, "n6_nrd");

      // n=10 started, reset after 4 edges
      wr(AN, 32'd10);
      wr(AG, 32'd1);
      repeat (4) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk(AN, 32'd0, "mid_rst_n");
      chk(AG, 32'd0, "mid_rst_go");
      chk(AS, 32'd0, "mid_rst_st");
      chk(AR, 32'd0, "mid_rst_res");
      @(negedge clk); rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk(AS, 32'd0, "after_rst_st");
      chk(AR, 32'd0, "after_rst_res");
`ifdef FACT_IRQ_EN
      chk_irq(1'b0, "after_rst_irq");
`endif

      // Fresh n=4 run -> 24
      wr(AN, 32'd4);
      wr(AG, 32'd1);
`ifdef FACT_IRQ_EN
      chk_irq(1'b0, "n4_irq_start");
`endif
      run_wait(4, 32'd24, "n4");
`ifdef FACT_IRQ_EN
      chk_irq(1'b1, "n4_irq_set");
      @(posedge clk); #1;
      chk_irq(1'b1, "n4_irq_hold");
      wr(AG, 32'd0);
      chk_irq(1'b0, "n4_irq_clr");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/soc_fact_unit.md
Name: soc_fact_unit

Overview:
- Memory-mapped iterative factorial accelerator on the SoC data bus.
- Sits directly downstream of the SoC address decoder:
  - its write-enable is the decoder's WE1 output (region A[7:4]=0x0);
  - its RD output feeds the SoC read-data mux input selected by RdSel=2'b10.
- Software writes n, pulses Go, polls status, then reads n!.

Parameters:
- N_W, 4, width of operand register n.
- DATA_W, 32, width of the data bus and result.
- MAX_N, 12, largest legal n; above this raises Err (12! = 479001600 fits 32 bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; all state clears while rst=0.
- WE   in  1  write strobe for this region, from decoder WE1.
- A    in  2  word select, bus address bits [3:2].
- WD   in  DATA_W  write data.
- RD   out DATA_W  read data; combinational from A and internal registers.

Behaviour:
- Register map, selected by A:
  - 00 n: RW; RD={0,n}.
  - 01 Go: RW; RD={0,go}.
  - 10 Status: RO; RD={0,Err,Done}, with Done in bit 0.
  - 11 Result: RO; RD=result.
- Writes (WE=1) take effect at the clock edge. Writes to 10/11 are ignored.
- Reset values: n=0, go=0, Done=0, Err=0, result=0, product=1, cnt=0, state=IDLE. RD then reads 0 for every A.
- Start pulse = WE & (A==01) & WD[0].
  - The go bit always latches WD[0] on a write to 01.
  - Only the pulse starts an operation.
- FSM states: IDLE, BUSY.
- IDLE + start, same edge:
  - Done, Err and result are cleared (Err rule overrides below).
  - If n>MAX_N: Err=1, Done=1, result=0, stay IDLE.
  - Otherwise: cnt=n (latched copy), product=1, go to BUSY.
- BUSY, each edge:
  - If cnt<=1: result=product, Done=1, go to IDLE.
  - Else: product=product*cnt (low DATA_W bits kept), cnt=cnt-1.
- Latency: Done rises exactly max(n,1) edges after the start edge. n=0 and n=1 both give result=1.
- Start while BUSY: ignored. The go bit still updates; no restart.
- Writing n while BUSY: the n register updates, but the computation uses the latched cnt.
- Done and Err are sticky until the next accepted start or reset.
- Start on the same edge that finishes BUSY: ignored, because the state is BUSY at that edge.
- rst low mid-operation: immediate return to reset values. No partial result is visible.
- RD has no read side effects.

Optional Feature:
- Macro FACT_IRQ_EN.
- When defined:
  - adds output irq (1 bit), reset 0;
  - irq=1 on the edge Done is set;
  - irq clears on any write to Go, or on reset.
- When undefined: no irq port, no extra logic. Register behaviour is identical.

Decomposition:
- Shared package soc_pkg holds:
  - register offset constants FACT_REG_N=2'b00, FACT_REG_GO=2'b01, FACT_REG_ST=2'b10, FACT_REG_RES=2'b11;
  - FSM state typedef fact_state_t {IDLE, BUSY};
  - MAX_N default.
- One sub-module fact_dp: cnt down-counter, multiplier and product register. Inputs load/step; outputs cnt_le1 and product.
- The top level keeps the register file, start decode, FSM and RD mux.

Test Plan:
- Reset then read all four addresses -> RD=0 for each; during reset, writes are ignored.
- n=5, Go=1 -> Status=01 on exactly the 5th edge after the start edge; Result=120. Poll before that -> Status=00.
- n=0 -> Done after 1 edge, Result=1. n=12 -> Done after 12 edges, Result=479001600 (0x1C8CFC00).
- n=13, Go=1 -> next cycle Status=11 and Result=0. Then n=3, Go=1 -> Status=01 after 3 edges, Result=6.
- n=6 started, then n=2 and Go=1 written while BUSY -> Result=720 after 6 edges; reads at A=00 give 2.
- n=10 started, rst pulsed low after 4 edges -> all reads 0. With FACT_IRQ_EN, irq=0 until a fresh n=4 run completes, then irq=1 until a Go write.
